// File: rtl/tanh_layer_gen_pkg.sv
// tanh_layer_gen_pkg: FSM state encodings and fixed-point PWL constant helper for the tanh layer.
package tanh_layer_gen_pkg;
  localparam logic [1:0] TL_IDLE = 2'd0;
  localparam logic [1:0] TL_RUN  = 2'd1;
  localparam logic [1:0] TL_DONE = 2'd2;
  function automatic int fxp(input int num, input int sh, input int frac);
    return num <<< (frac - sh);
  endfunction
endpackage

// File: rtl/tanh_layer_gen_lane.sv
// tanh_lane: one element of PWL tanh (forward) and saturated d*(1-y^2) (backward), purely combinational.
module tanh_lane
  import tanh_layer_gen_pkg::*;
#(
  parameter int N_LEN   = 16,
  parameter int FRAC    = 10,
  parameter int N_LEN_W = 8
) (
  input  logic signed [N_LEN-1:0]   x_i,
  input  logic signed [N_LEN-1:0]   d_i,
  input  logic signed [N_LEN_W-1:0] y_i,
  output logic signed [N_LEN_W-1:0] y_o,
  output logic signed [N_LEN-1:0]   q_o
);
  localparam int YF = N_LEN_W - 2;
  localparam int GW = 2 * N_LEN_W + 2;
  localparam int PW = N_LEN + GW;
  localparam logic [N_LEN-1:0] C_HALF  = N_LEN'(fxp(1, 1, FRAC));
  localparam logic [N_LEN-1:0] C_TWO   = N_LEN'(fxp(2, 0, FRAC));
  localparam logic [N_LEN-1:0] C_THREE = N_LEN'(fxp(3, 0, FRAC));
  localparam logic [N_LEN-1:0] C_P375  = N_LEN'(fxp(3, 3, FRAC));
  localparam logic [N_LEN-1:0] C_P75   = N_LEN'(fxp(3, 2, FRAC));
  localparam logic [N_LEN-1:0] C_P9375 = N_LEN'(fxp(15, 4, FRAC));
  localparam logic signed [GW-1:0] ONE  = GW'(longint'(1) <<< (2 * YF));
  localparam logic signed [PW-1:0] QMAX = PW'((longint'(1) <<< (N_LEN - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN = -QMAX - 1;
  logic [N_LEN-1:0] a, m;
  logic signed [N_LEN-1:0] s;
  logic signed [GW-1:0] yy, g;
  logic signed [PW-1:0] dd, gg, r;
  // |x| is unsigned so the most negative input still lands in the saturated segment
  always_comb begin
    a   = x_i[N_LEN-1] ? N_LEN'(-x_i) : x_i;
    m   = a < C_HALF ? a : a < C_TWO ? (a >> 2) + C_P375 : a < C_THREE ? (a >> 4) + C_P75 : C_P9375;
    s   = x_i[N_LEN-1] ? -m : m;
    y_o = N_LEN_W'(s >>> (FRAC - YF));
    yy  = GW'(y_i);
    g   = ONE - yy * yy;
    dd  = PW'(d_i);
    gg  = PW'(g);
    r   = (dd * gg) >>> (2 * YF);
    q_o = r > QMAX ? N_LEN'(QMAX) : r < QMIN ? N_LEN'(QMIN) : N_LEN'(r);
  end
endmodule

// File: rtl/tanh_layer_gen.sv
// tanh_layer_gen: lane-serial tanh layer with per-slot forward contexts for the backward pass.
// TANH_LAYER_SNAPSHOT_EN adds a shadow context bank and lets forward and backward overlap.
module tanh_layer_gen
  import tanh_layer_gen_pkg::*;
#(
  parameter int ELEMS     = 64,
  parameter int LANES     = 16,
  parameter int NUM_SLOTS = 3,
  parameter int N_LEN     = 16,
  parameter int FRAC      = 10,
  parameter int N_LEN_W   = 8,
  parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run_forward,
  input  logic                       run_backward,
  input  logic                       load_backward,
  input  logic [SW-1:0]              slot_forward,
  input  logic [SW-1:0]              slot_backward,
  input  logic [ELEMS*N_LEN-1:0]     d_forward,
  input  logic [ELEMS*N_LEN-1:0]     d_backward,
  output logic                       valid_forward,
  output logic                       valid_backward,
  output logic                       busy_forward,
  output logic                       busy_backward,
  output logic                       err_backward,
  output logic [ELEMS*N_LEN_W-1:0]   q_forward,
  output logic [ELEMS*N_LEN-1:0]     q_backward
);
  localparam int B  = ELEMS / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int CW = ELEMS * N_LEN_W;
  logic [1:0] fs_q, fs_d, bs_q, bs_d;
  logic [BW-1:0] fb_q, bb_q;
  logic [ELEMS*N_LEN-1:0] fx_q, bd_q, qb_q;
  logic [CW-1:0] qf_q;
  logic [SW-1:0] fslot_q, bslot_q;
  logic [CW-1:0] ctx_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] vld_q;
  logic err_q, start_f, start_b, rvld;
  logic [CW-1:0] rctx;
  logic signed [N_LEN_W-1:0] yl [LANES];
  logic signed [N_LEN-1:0] ql [LANES];
`ifdef TANH_LAYER_SNAPSHOT_EN
  logic [CW-1:0] sh_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] shv_q;
  logic pend_q;
  assign start_f = run_forward && fs_q == TL_IDLE;
  assign start_b = run_backward && bs_q == TL_IDLE;
  // the shadow bank only changes while backward is idle; a busy-time load waits in pend_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) sh_q[i] <= '0;
      shv_q  <= '0;
      pend_q <= 1'b0;
    end else if (bs_q == TL_IDLE && (load_backward || pend_q)) begin
      sh_q   <= ctx_q;
      shv_q  <= vld_q;
      pend_q <= 1'b0;
    end else if (load_backward) pend_q <= 1'b1;
  end
  always_comb begin
    rctx = '0;
    rvld = 1'b0;
    if (int'(bslot_q) < NUM_SLOTS) begin
      rctx = sh_q[bslot_q];
      rvld = shv_q[bslot_q];
    end
  end
`else
  logic unused_ld;
  assign unused_ld = load_backward;
  assign start_f = run_forward && fs_q == TL_IDLE && bs_q == TL_IDLE;
  assign start_b = run_backward && bs_q == TL_IDLE && fs_q == TL_IDLE && !run_forward;
  always_comb begin
    rctx = '0;
    rvld = 1'b0;
    if (int'(bslot_q) < NUM_SLOTS) begin
      rctx = ctx_q[bslot_q];
      rvld = vld_q[bslot_q];
    end
  end
`endif
  assign fs_d = fs_q == TL_IDLE ? (start_f ? TL_RUN : TL_IDLE) :
                fs_q == TL_RUN  ? (fb_q == BW'(B - 1) ? TL_DONE : TL_RUN) : TL_IDLE;
  assign bs_d = bs_q == TL_IDLE ? (start_b ? TL_RUN : TL_IDLE) :
                bs_q == TL_RUN  ? (bb_q == BW'(B - 1) ? TL_DONE : TL_RUN) : TL_IDLE;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tanh_lane #(.N_LEN(N_LEN), .FRAC(FRAC), .N_LEN_W(N_LEN_W)) u_lane (
      .x_i(fx_q[(int'(fb_q) * LANES + l) * N_LEN +: N_LEN]),
      .d_i(bd_q[(int'(bb_q) * LANES + l) * N_LEN +: N_LEN]),
      .y_i(rvld ? rctx[(int'(bb_q) * LANES + l) * N_LEN_W +: N_LEN_W] : '0),
      .y_o(yl[l]),
      .q_o(ql[l])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs_q    <= TL_IDLE;
      bs_q    <= TL_IDLE;
      fb_q    <= '0;
      bb_q    <= '0;
      fx_q    <= '0;
      bd_q    <= '0;
      fslot_q <= '0;
      bslot_q <= '0;
      qf_q    <= '0;
      qb_q    <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) ctx_q[i] <= '0;
    end else begin
      fs_q <= fs_d;
      bs_q <= bs_d;
      if (start_f) begin
        fx_q    <= d_forward;
        fslot_q <= slot_forward;
        fb_q    <= '0;
      end
      if (fs_q == TL_RUN) begin
        fb_q <= fb_q + 1'b1;
        for (int i = 0; i < LANES; i++) qf_q[(int'(fb_q) * LANES + i) * N_LEN_W +: N_LEN_W] <= yl[i];
      end
      if (fs_q == TL_DONE && int'(fslot_q) < NUM_SLOTS) begin
        ctx_q[fslot_q] <= qf_q;
        vld_q[fslot_q] <= 1'b1;
      end
      if (start_b) begin
        bd_q    <= d_backward;
        bslot_q <= slot_backward;
        bb_q    <= '0;
      end
      if (bs_q == TL_RUN) begin
        bb_q <= bb_q + 1'b1;
        for (int i = 0; i < LANES; i++) qb_q[(int'(bb_q) * LANES + i) * N_LEN +: N_LEN] <= ql[i];
        if (!rvld) err_q <= 1'b1;
      end
    end
  end
  assign valid_forward  = fs_q == TL_DONE;
  assign valid_backward = bs_q == TL_DONE;
  assign busy_forward   = fs_q != TL_IDLE;
  assign busy_backward  = bs_q != TL_IDLE;
  assign err_backward   = err_q;
  assign q_forward      = qf_q;
  assign q_backward     = qb_q;
endmodule

// File: tb/tb_tanh_layer_gen.sv
// tb_tanh_layer_gen: table vectors plus randomized passes checked against a real-valued tanh layer model.
module tb_tanh_layer_gen;
  localparam int E = 64, L = 16, NS = 3, NL = 16, NW = 8, B = E / L;
  logic clk = 1'b0, rst_n = 1'b0;
  logic run_forward = 1'b0, run_backward = 1'b0, load_backward = 1'b0;
  logic [1:0] slot_forward = '0, slot_backward = '0;
  logic [E*NL-1:0] d_forward = '0, d_backward = '0;
  logic valid_forward, valid_backward, busy_forward, busy_backward, err_backward;
  logic [E*NW-1:0] q_forward;
  logic [E*NL-1:0] q_backward;
  int errors = 0, checks = 0;
  int xv[E], dv[E];
  int live_y[NS][E], sh_y[NS][E];
  bit live_v[NS], sh_v[NS];
  bit err_exp;
  typedef struct {int x; int y;} fv_t;
  fv_t tbl[13];

  tanh_layer_gen #(.ELEMS(E), .LANES(L), .NUM_SLOTS(NS), .N_LEN(NL), .FRAC(10), .N_LEN_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .run_forward(run_forward), .run_backward(run_backward),
    .load_backward(load_backward), .slot_forward(slot_forward), .slot_backward(slot_backward),
    .d_forward(d_forward), .d_backward(d_backward), .valid_forward(valid_forward),
    .valid_backward(valid_backward), .busy_forward(busy_forward), .busy_backward(busy_backward),
    .err_backward(err_backward), .q_forward(q_forward), .q_backward(q_backward)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int fwd_ref(input int xr);
    real a, m;
    int s;
    a = (xr < 0 ? -xr : xr) / 1024.0;
    m = a < 0.5 ? a : a < 2.0 ? a / 4.0 + 0.375 : a < 3.0 ? a / 16.0 + 0.75 : 0.9375;
    s = int'($floor(m * 1024.0));
    if (xr < 0) s = -s;
    return int'($floor(s / 16.0));
  endfunction

  function automatic int bwd_ref(input int d, input int y, input bit v);
    real yr, p;
    yr = v ? y / 64.0 : 0.0;
    p = $floor(d * (1.0 - yr * yr));
    return p > 32767.0 ? 32767 : p < -32768.0 ? -32768 : int'(p);
  endfunction

  function automatic int qf(input int i);
    return int'($signed(q_forward[i*NW +: NW]));
  endfunction

  function automatic int qb(input int i);
    return int'($signed(q_backward[i*NL +: NL]));
  endfunction

  function automatic bit bank_v(input int s);
`ifdef TANH_LAYER_SNAPSHOT_EN
    return s < NS && sh_v[s];
`else
    return s < NS && live_v[s];
`endif
  endfunction

  function automatic int bank_y(input int s, input int i);
`ifdef TANH_LAYER_SNAPSHOT_EN
    return sh_y[s][i];
`else
    return live_y[s][i];
`endif
  endfunction

  function automatic int rnd16();
    return $urandom_range(0, 1) ? int'(shortint'($urandom)) : int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic fwd(input int slot, input bit ld_done, input bit rerun);
    int first = 0, vcnt = 0, bad = -1, idx;
    int exp_y[E];
    for (int i = 0; i < E; i++) begin
      d_forward[i*NL +: NL] = 16'(xv[i]);
      exp_y[i] = fwd_ref(xv[i]);
    end
    slot_forward = 2'(slot);
    run_forward = 1'b1;
    for (int n = 1; n <= B + 3; n++) begin
      @(negedge clk);
      run_forward = rerun && n == 2;
      if (valid_forward) begin
        vcnt++;
        if (first == 0) first = n;
      end
      if (n == 1) chk("fwd_busy_start", int'(busy_forward), 1);
      if (n == B + 2) chk("fwd_busy_idle", int'(busy_forward), 0);
      load_backward = ld_done && valid_forward;
    end
    chk("fwd_valid_cycle", first, B + 1);
    chk("fwd_valid_count", vcnt, 1);
    for (int i = 0; i < E; i++) if (qf(i) != exp_y[i] && bad < 0) bad = i;
    idx = bad < 0 ? 0 : bad;
    chk($sformatf("fwd_q[%0d]", idx), qf(idx), exp_y[idx]);
`ifdef TANH_LAYER_SNAPSHOT_EN
    if (ld_done) begin
      sh_y = live_y;
      sh_v = live_v;
    end
`endif
    if (slot < NS) begin
      for (int i = 0; i < E; i++) live_y[slot][i] = exp_y[i];
      live_v[slot] = 1'b1;
    end
  endtask

  task automatic bwd(input int slot);
    int first = 0, vcnt = 0, bad = -1, idx;
    int exp_q[E];
    bit v;
    v = bank_v(slot);
    for (int i = 0; i < E; i++) begin
      d_backward[i*NL +: NL] = 16'(dv[i]);
      exp_q[i] = bwd_ref(dv[i], v ? bank_y(slot, i) : 0, v);
    end
    if (!v) err_exp = 1'b1;
    slot_backward = 2'(slot);
    run_backward = 1'b1;
    for (int n = 1; n <= B + 3; n++) begin
      @(negedge clk);
      run_backward = 1'b0;
      if (valid_backward) begin
        vcnt++;
        if (first == 0) first = n;
      end
      if (n == 1) chk("bwd_busy_start", int'(busy_backward), 1);
      if (n == B + 2) chk("bwd_busy_idle", int'(busy_backward), 0);
    end
    chk("bwd_valid_cycle", first, B + 1);
    chk("bwd_valid_count", vcnt, 1);
    for (int i = 0; i < E; i++) if (qb(i) != exp_q[i] && bad < 0) bad = i;
    idx = bad < 0 ? 0 : bad;
    chk($sformatf("bwd_q[%0d]", idx), qb(idx), exp_q[idx]);
    chk("err_backward", int'(err_backward), int'(err_exp));
  endtask

  task automatic ld();
    load_backward = 1'b1;
    @(negedge clk);
    load_backward = 1'b0;
`ifdef TANH_LAYER_SNAPSHOT_EN
    sh_y = live_y;
    sh_v = live_v;
`endif
  endtask

  task automatic fill_x(input int val);
    for (int i = 0; i < E; i++) xv[i] = val;
  endtask

  task automatic fill_d(input int val);
    for (int i = 0; i < E; i++) dv[i] = val;
  endtask

  initial begin
    int vseen;
    tbl = '{'{256, 16}, '{1024, 40}, '{-2560, -58}, '{10240, 60}, '{0, 0}, '{512, 32}, '{511, 31},
            '{2048, 56}, '{3072, 60}, '{-32768, -60}, '{-1, -1}, '{32767, 60}, '{-512, -32}};
    for (int s = 0; s < NS; s++) begin
      live_v[s] = 1'b0;
      sh_v[s] = 1'b0;
      for (int i = 0; i < E; i++) begin
        live_y[s][i] = 0;
        sh_y[s][i] = 0;
      end
    end
    err_exp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_f", int'(valid_forward), 0);
    chk("rst_valid_b", int'(valid_backward), 0);
    chk("rst_busy_f", int'(busy_forward), 0);
    chk("rst_busy_b", int'(busy_backward), 0);
    chk("rst_err", int'(err_backward), 0);
    chk("rst_qf", int'(|q_forward), 0);
    chk("rst_qb", int'(|q_backward), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < E; i++) xv[i] = rnd16();
    for (int i = 0; i < 13; i++) xv[i*4] = tbl[i].x;
    fwd(0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) chk($sformatf("tbl%0d", i), qf(i*4), tbl[i].y);
    for (int i = 0; i < E; i++) dv[i] = rnd16();
    bwd(2);
    chk("inv_q_eq_d", qb(7), dv[7]);
    chk("inv_err", int'(err_backward), 1);
    fill_x(512);
    fwd(1, 1'b0, 1'b0);
    ld();
    fill_d(1024);
    bwd(1);
    chk("bwd_0p75", qb(0), 768);
    fill_x(0);
    fwd(0, 1'b0, 1'b0);
    ld();
    for (int i = 0; i < E; i++) dv[i] = rnd16();
    dv[0] = -31744;
    dv[1] = -32768;
    dv[2] = 32767;
    bwd(0);
    chk("sat_m31", qb(0), -31744);
    chk("sat_min", qb(1), -32768);
    chk("sat_max", qb(2), 32767);
    chk("err_sticky", int'(err_backward), 1);
`ifdef TANH_LAYER_SNAPSHOT_EN
    fill_x(512);
    fwd(0, 1'b0, 1'b0);
    ld();
    fill_x(0);
    fwd(0, 1'b0, 1'b0);
    fill_d(1024);
    bwd(0);
    chk("snap_iso", qb(0), 768);
`endif
    for (int i = 0; i < E; i++) xv[i] = rnd16();
    fwd(2, 1'b0, 1'b1);
    fill_x(-2560);
    fwd(0, 1'b1, 1'b0);
    fill_d(1024);
    bwd(0);
`ifdef TANH_LAYER_SNAPSHOT_EN
    chk("done_edge_ld", qb(0), 1024);
`else
    chk("done_edge_live", qb(0), 183);
`endif
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < E; i++) xv[i] = rnd16();
      fwd($urandom_range(0, 3), 1'b0, 1'b0);
      if ($urandom_range(0, 1)) ld();
      for (int i = 0; i < E; i++) dv[i] = rnd16();
      bwd($urandom_range(0, 3));
    end
    for (int i = 0; i < E; i++) d_forward[i*NL +: NL] = 16'(rnd16());
    slot_forward = 2'd1;
    run_forward = 1'b1;
    @(negedge clk);
    run_forward = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(valid_forward), 0);
    chk("mid_rst_busy", int'(busy_forward), 0);
    chk("mid_rst_qf", int'(|q_forward), 0);
    chk("mid_rst_qb", int'(|q_backward), 0);
    chk("mid_rst_err", int'(err_backward), 0);
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) begin
      live_v[s] = 1'b0;
      sh_v[s] = 1'b0;
      for (int i = 0; i < E; i++) begin
        live_y[s][i] = 0;
        sh_y[s][i] = 0;
      end
    end
    err_exp = 1'b0;
    vseen = 0;
    repeat (B + 3) begin
      @(negedge clk);
      if (valid_forward) vseen++;
    end
    chk("mid_rst_no_valid", vseen, 0);
    ld();
    for (int i = 0; i < E; i++) dv[i] = rnd16();
    bwd(1);
    chk("mid_rst_ctx_clr", qb(3), dv[3]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
